stopwatch_display: RTL

Four-digit BCD stopwatch with a multiplexed seven-segment driver. It sits directly downstream of the clock divider and consumes the divider's square-wave output as a level input on `tick_in`. The block edge-detects that input in the `clock_in` domain, counts rising edges while running, and scans the count onto a common-anode 4-digit display. Everything runs on `clock_in`; the divided signal is never used as a clock.

---
 rtl/stopwatch_display.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_display.sv
// -----------------------------------------------------------------------------
// stopwatch_display
//
// Four-digit BCD stopwatch with a multiplexed common-anode seven-segment
// driver. The divided square wave on tick_in is sampled as a level in the
// clock_in domain; each rising edge seen while running adds one to the count.
// The count is scanned one digit at a time onto the display.
//
// Parameters
//   SCAN_DIV   clock_in cycles each digit stays enabled (2..65535)
//
// Ports
//   clock_in   in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   tick_in    in   divider output (level); each rising edge is one event
//   start_stop in   one-cycle pulse, toggles run/pause
//   clear      in   one-cycle pulse, zeroes the count (wins over increment)
//   count      out  BCD count, [15:12] thousands .. [3:0] units
//   running    out  1 while counting is enabled
//   wrap       out  one-cycle pulse coincident with the 9999->0000 rollover
//   anode      out  active-low digit enables, bit n = digit n (0 = units)
//   segments   out  active-low segments, {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module stopwatch_display #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] count,
  output logic        running,
  output logic        wrap,
  output logic [3:0]  anode,
  output logic [6:0]  segments
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic        tick_q;
  logic        running_q, running_d;
  logic [15:0] count_q, count_d;
  logic        wrap_q, wrap_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  sel_q, sel_d;

  logic        tick_event;
  logic        do_inc;
  logic [15:0] count_inc;
  logic        carry;
  logic [3:0]  digit;

  // Rising edge of the divider output, detected against last cycle's level.
  assign tick_event = tick_in & ~tick_q;
  // Increment decision uses the pre-toggle running state.
  assign do_inc     = tick_event & running_q;

  // BCD +1: ripple a carry upward; a 9 rolls to 0 and passes the carry on,
  // anything else absorbs it and leaves higher digits untouched.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    running_d = running_q ^ start_stop;
    count_d   = count_q;
    wrap_d    = 1'b0;
    if (clear) begin
      count_d = 16'h0000;
    end else if (do_inc) begin
      count_d = count_inc;
      wrap_d  = (count_q == 16'h9999);
    end
  end

  // Scan timing: hold each digit SCAN_DIV cycles, then step to the next one.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    sel_d      = sel_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      sel_d      = sel_q + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      count_q    <= 16'h0000;
      wrap_q     <= 1'b0;
      scan_cnt_q <= 16'd0;
      sel_q      <= 2'd0;
    end else begin
      tick_q     <= tick_in;
      running_q  <= running_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
    end
  end

  // Digit currently on the display.
  always_comb begin
    case (sel_q)
      2'd0:    digit = count_q[3:0];
      2'd1:    digit = count_q[7:4];
      2'd2:    digit = count_q[11:8];
      default: digit = count_q[15:12];
    endcase
  end

  always_comb begin
    anode        = 4'b1111;
    anode[sel_q] = 1'b0;
  end

  // Active-low decode, {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  always_comb begin
    case (digit)
      4'd0:    segments = 7'b1000000;
      4'd1:    segments = 7'b1111001;
      4'd2:    segments = 7'b0100100;
      4'd3:    segments = 7'b0110000;
      4'd4:    segments = 7'b0011001;
      4'd5:    segments = 7'b0010010;
      4'd6:    segments = 7'b0000010;
      4'd7:    segments = 7'b1111000;
      4'd8:    segments = 7'b0000000;
      4'd9:    segments = 7'b0010000;
      default: segments = 7'b1111111;
    endcase
  end

  assign count   = count_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule
